// File: rtl/axi_reg_map_param.sv
// ---------------------------------------------------------------------------
// axi_reg_map_param
//
// AXI4-Lite slave register map with NUM_CTRL read/write control registers
// and NUM_STAT read-only status registers. The write address and write data
// are accepted independently into one-deep holding registers and committed
// together. The read response is registered and held until it is accepted.
//
// Address map (only addr[15:0] is decoded):
//   CTRL_BASE + 1 + k : control register k (R/W, byte strobes honoured)
//   STAT_BASE + 1 + k : status register k  (R only; writes return SLVERR)
//   anything else     : DECERR (reads return 0x0BAD0BAD)
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   s_axi_aw*            write address channel
//   s_axi_w*             write data channel (with byte strobes)
//   s_axi_b*             write response channel
//   s_axi_ar*            read address channel
//   s_axi_r*             read data channel
//   ctrl_regs            flat control register contents, reg k at slice k
//   rst_ctrl_reg         per-register restore-to-default request
//   ctrl_wr_pulse        1-cycle pulse when control reg k is written
//   status_regs          flat status inputs, reg k at slice k
//   stat_rd_pulse        1-cycle pulse when status reg k is read
// ---------------------------------------------------------------------------
module axi_reg_map_param #(
  parameter int                             NUM_CTRL     = 8,
  parameter int                             NUM_STAT     = 8,
  parameter int                             DATA_WIDTH   = 32,
  parameter int                             ADDR_WIDTH   = 32,
  parameter logic [15:0]                    CTRL_BASE    = 16'h0000,
  parameter logic [15:0]                    STAT_BASE    = 16'h1000,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_DEFAULT = {NUM_CTRL{32'hAABBCCDD}}
) (
  input  logic                           clk,
  input  logic                           reset,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  // write response channel
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  // register side
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
  input  logic [NUM_CTRL-1:0]            rst_ctrl_reg,
  output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] status_regs,
  output logic [NUM_STAT-1:0]            stat_rd_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [DATA_WIDTH-1:0] RDATA_RST = DATA_WIDTH'(32'hDEADDEAD);
  localparam logic [DATA_WIDTH-1:0] RDATA_BAD = DATA_WIDTH'(32'h0BAD0BAD);

  // Offset of an address from the first register of a bank. Done in 17 bits
  // so that addresses at or below the base wrap to a large value and fail
  // the "offset < count" bank test without a separate lower-bound compare.
  function automatic logic [16:0] reg_off(input logic [15:0] addr,
                                          input logic [15:0] base);
    return {1'b0, addr} - {1'b0, base} - 17'd1;
  endfunction

  // Byte-lane merge of new data into an existing register value.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Upper address bits are intentionally not decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // -------------------------------------------------------------------------
  // Write path state
  // -------------------------------------------------------------------------
  logic                           aw_held_q, aw_held_d;
  logic [15:0]                    awaddr_q,  awaddr_d;
  logic                           w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0]          wdata_q,   wdata_d;
  logic [STRB_W-1:0]              wstrb_q,   wstrb_d;
  logic                           bvalid_q,  bvalid_d;
  logic [1:0]                     bresp_q,   bresp_d;
  logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_q,    ctrl_d;
  logic [NUM_CTRL-1:0]            wr_pulse_q, wr_pulse_d;

  logic        aw_hs, w_hs, b_hs, commit;
  logic [16:0] wr_coff, wr_soff;
  logic        wr_is_ctrl, wr_is_stat;

  // No new AW/W while a response is pending: keeps one write in flight.
  assign s_axi_awready = !aw_held_q && !bvalid_q;
  assign s_axi_wready  = !w_held_q  && !bvalid_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid  && s_axi_wready;
  assign b_hs   = bvalid_q && s_axi_bready;
  // Both halves must already be registered, so a same-edge AW+W handshake
  // commits on the following edge.
  assign commit = aw_held_q && w_held_q;

  assign wr_coff    = reg_off(awaddr_q, CTRL_BASE);
  assign wr_soff    = reg_off(awaddr_q, STAT_BASE);
  assign wr_is_ctrl = wr_coff < 17'(NUM_CTRL);
  assign wr_is_stat = wr_soff < 17'(NUM_STAT);

  always_comb begin
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ctrl_d     = ctrl_q;
    wr_pulse_d = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr[15:0];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end
    if (b_hs) bvalid_d = 1'b0;

    // Restore first so that a commit to the same register overrides it.
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (rst_ctrl_reg[k]) begin
        ctrl_d[k*DATA_WIDTH +: DATA_WIDTH] = CTRL_DEFAULT[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_is_ctrl) begin
        bresp_d = RESP_OKAY;
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (wr_coff == 17'(k)) begin
            ctrl_d[k*DATA_WIDTH +: DATA_WIDTH] =
              byte_merge(ctrl_q[k*DATA_WIDTH +: DATA_WIDTH], wdata_q, wstrb_q);
            wr_pulse_d[k] = |wstrb_q;
          end
        end
      end else if (wr_is_stat) begin
        bresp_d = RESP_SLVERR;
      end else begin
        bresp_d = RESP_DECERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      ctrl_q     <= CTRL_DEFAULT;
      wr_pulse_q <= '0;
    end else begin
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ctrl_q     <= ctrl_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Holding data registers are qualified by the held flags and need no reset.
  always_ff @(posedge clk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign ctrl_regs     = ctrl_q;
  assign ctrl_wr_pulse = wr_pulse_q;

  // -------------------------------------------------------------------------
  // Read path state
  // -------------------------------------------------------------------------
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q,  rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [NUM_STAT-1:0]   rd_pulse_q, rd_pulse_d;

  logic        ar_hs, r_hs;
  logic [16:0] rd_coff, rd_soff;
  logic        rd_is_ctrl, rd_is_stat;

  assign s_axi_arready = !rvalid_q;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign r_hs  = rvalid_q && s_axi_rready;

  assign rd_coff    = reg_off(s_axi_araddr[15:0], CTRL_BASE);
  assign rd_soff    = reg_off(s_axi_araddr[15:0], STAT_BASE);
  assign rd_is_ctrl = rd_coff < 17'(NUM_CTRL);
  assign rd_is_stat = rd_soff < 17'(NUM_STAT);

  always_comb begin
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_pulse_d = '0;

    if (r_hs) rvalid_d = 1'b0;

    // ctrl_q is the pre-commit value, so a same-edge write is not visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (rd_is_ctrl) begin
        rresp_d = RESP_OKAY;
        for (int k = 0; k < NUM_CTRL; k++) begin
          if (rd_coff == 17'(k)) rdata_d = ctrl_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (rd_is_stat) begin
        rresp_d = RESP_OKAY;
        for (int k = 0; k < NUM_STAT; k++) begin
          if (rd_soff == 17'(k)) begin
            rdata_d       = status_regs[k*DATA_WIDTH +: DATA_WIDTH];
            rd_pulse_d[k] = 1'b1;
          end
        end
      end else begin
        rresp_d = RESP_DECERR;
        rdata_d = RDATA_BAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= RDATA_RST;
      rd_pulse_q <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign stat_rd_pulse = rd_pulse_q;

endmodule
